eth_rx_ctrl: RTL

Receive-path sequencer for the Ethernet interface. Accepts the byte stream from the receiver front end, writes it into a two-page receive buffer, drives the MAC destination filter's framing, address and write-strobe inputs, and commits or discards each frame on the filter verdict. Completed frames are handed to the CPU through per-page ready flags, length registers and acknowledge strobes.

---
 rtl/eth_rx_pkg.sv | 26 ++
 rtl/eth_rx_page.sv | 27 ++
 rtl/eth_rx_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/eth_rx_pkg.sv
// Shared types and sizing for the Ethernet receive sequencer: state encoding, frame limits, buffer address layout.
// Combinational helpers only; no storage and no flow control.
package eth_rx_pkg;

  localparam int MAX_LEN = 1536;
  localparam int HDR_LEN = 7;
  localparam int OFS_W   = 11;
  localparam int ADDR_W  = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    BODY = 2'd2,
    DROP = 2'd3
  } rx_state_t;

  typedef struct packed {
    logic             page;
    logic [OFS_W-1:0] ofs;
  } buf_addr_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/eth_rx_page.sv
// One receive page's full flag and committed length; set/len-load wins over ack-clear.
// One-cycle registered update; ack on an empty page has no effect.
module eth_rx_page
  import eth_rx_pkg::*;
(
  input  logic             clk,
  input  logic             n_rst,
  input  logic             set,
  input  logic [OFS_W-1:0] len_in,
  input  logic             ack,
  output logic             rdy,
  output logic [OFS_W-1:0] len
);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rdy <= 1'b0;
      len <= '0;
    end else if (set) begin
      rdy <= 1'b1;
      len <= len_in;
    end else if (ack) begin
      rdy <= 1'b0;
    end
  end

endmodule

// File: rtl/eth_rx_ctrl.sv
// Receive sequencer: writes bytes into a two-page buffer, frames the MAC filter, commits or drops on its verdict.
// One-cycle registered write strobes; no backpressure, bad frames are counted and dropped. Optional ETH_RX_PROMISC_EN.
module eth_rx_ctrl
  import eth_rx_pkg::*;
(
  input  logic              clk,
  input  logic              n_rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              rx_sof,
  input  logic              rx_last,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [7:0]        buf_wdata,
  output logic              n_buf_we,
  output logic              filt_ss,
  output logic [3:0]        filt_a,
  output logic              filt_n_we,
  input  logic              filt_n_inhibit,
`ifdef ETH_RX_PROMISC_EN
  input  logic              promisc,
`endif
  output logic [1:0]        rdy,
  output logic [OFS_W-1:0]  len0,
  output logic [OFS_W-1:0]  len1,
  input  logic [1:0]        ack,
  output logic [7:0]        drop_cnt
);

  rx_state_t        state, state_n, eff;
  logic [OFS_W-1:0] offset, offset_n, wr_ofs, commit_len;
  logic             wr_page, cur_page, cur_page_n, pg_sel, commit_page, commit_vld;
  logic             accept, hdr_done, start, drop, commit, wr_en;
  logic [1:0]       page_full;
  buf_addr_t        addr_q;

`ifdef ETH_RX_PROMISC_EN
  assign accept = filt_n_inhibit | promisc;
`else
  assign accept = filt_n_inhibit;
`endif

  // A commit still in flight to the page registers already owns that page.
  assign page_full[0] = (rdy[0] & ~ack[0]) | (commit_vld & ~commit_page);
  assign page_full[1] = (rdy[1] & ~ack[1]) | (commit_vld & commit_page);

  assign buf_addr = addr_q;
  assign filt_a   = addr_q.ofs[3:0];
  assign filt_ss  = (state == HDR);

  always_comb begin
    eff        = state;
    offset_n   = offset;
    cur_page_n = cur_page;
    wr_ofs     = offset;
    pg_sel     = wr_page;
    start      = 1'b0;
    drop       = 1'b0;
    commit     = 1'b0;
    wr_en      = 1'b0;
    // Verdict is taken once the last header strobe has returned high.
    hdr_done   = (state == HDR) && (offset == OFS_W'(HDR_LEN)) && n_buf_we;
    if (hdr_done) begin
      if (accept) begin
        eff = BODY;
      end else begin
        eff  = DROP;
        drop = 1'b1;
      end
    end
    state_n = eff;

    if (rx_valid) begin
      if (eff == IDLE || eff == DROP) begin
        if (rx_sof) begin
          start = 1'b1;
        end else if (eff == DROP && rx_last) begin
          state_n = IDLE;
        end
      end else if (!n_buf_we) begin
        drop    = 1'b1;
        state_n = rx_last ? IDLE : DROP;
      end else if (rx_sof) begin
        drop  = 1'b1;
        start = 1'b1;
      end else if (eff == BODY && offset == OFS_W'(MAX_LEN)) begin
        drop    = 1'b1;
        state_n = rx_last ? IDLE : DROP;
      end else begin
        wr_en    = 1'b1;
        offset_n = offset + 1'b1;
        if (rx_last) begin
          state_n = IDLE;
          if (eff == BODY) commit = 1'b1;
          else             drop   = 1'b1;
        end
      end
    end

    if (start) begin
      pg_sel = page_full[wr_page] ? ~wr_page : wr_page;
      if (&page_full) begin
        drop    = 1'b1;
        state_n = rx_last ? IDLE : DROP;
      end else begin
        cur_page_n = pg_sel;
        wr_en      = 1'b1;
        wr_ofs     = '0;
        offset_n   = OFS_W'(1);
        state_n    = rx_last ? IDLE : HDR;
        if (rx_last) drop = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= IDLE;
      offset      <= '0;
      cur_page    <= 1'b0;
      wr_page     <= 1'b0;
      addr_q      <= '0;
      buf_wdata   <= 8'd0;
      n_buf_we    <= 1'b1;
      filt_n_we   <= 1'b1;
      drop_cnt    <= 8'd0;
      commit_vld  <= 1'b0;
      commit_page <= 1'b0;
      commit_len  <= '0;
    end else begin
      state      <= state_n;
      offset     <= offset_n;
      cur_page   <= cur_page_n;
      n_buf_we   <= ~wr_en;
      filt_n_we  <= ~(wr_en && state_n == HDR);
      commit_vld <= commit;
      if (wr_en) begin
        addr_q    <= '{page: cur_page_n, ofs: wr_ofs};
        buf_wdata <= rx_data;
      end
      if (commit) begin
        commit_page <= cur_page;
        commit_len  <= offset + 1'b1;
        wr_page     <= ~cur_page;
      end
      if (drop) drop_cnt <= sat_inc(drop_cnt);
    end
  end

  eth_rx_page u_page0 (
    .clk    (clk),
    .n_rst  (n_rst),
    .set    (commit_vld & ~commit_page),
    .len_in (commit_len),
    .ack    (ack[0]),
    .rdy    (rdy[0]),
    .len    (len0)
  );

  eth_rx_page u_page1 (
    .clk    (clk),
    .n_rst  (n_rst),
    .set    (commit_vld & commit_page),
    .len_in (commit_len),
    .ack    (ack[1]),
    .rdy    (rdy[1]),
    .len    (len1)
  );

endmodule
